// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: arbitrates fetch and load/store ports onto a single-word memory bus.
// Optional build macro MEMCTL_ADDR_CHECK_EN rejects word addresses >= MEM_DEPTH and reports them on err.
module mem_bus_ctrl #(
    parameter int MEM_DEPTH = 128,
    parameter bit BYTE_ADDR = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
`ifdef MEMCTL_ADDR_CHECK_EN
    output logic        err,
`endif
    output logic        CS,
    output logic        WE,
    output logic [31:0] ADDR,
    inout  wire  [31:0] Mem_Bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        logic [31:0] w;
        if (BYTE_ADDR) begin
            w = {2'b00, a[31:2]};
        end else begin
            w = a;
        end
        return w;
    endfunction

    state_t      state_r;
    logic        grant_d_r;
    logic        cs_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] if_rdata_r;
    logic [31:0] d_rdata_r;
    logic        if_ack_r;
    logic        d_ack_r;

    logic        req_any_s;
    logic        req_we_s;
    logic [31:0] req_addr_s;
    logic        unused_bits_s;

`ifdef MEMCTL_ADDR_CHECK_EN
    logic        err_r;
    logic        addr_bad_s;
    assign addr_bad_s = (req_addr_s >= 32'(MEM_DEPTH));
`endif

    // Fixed-priority request selection: the data port always wins over fetch.
    always_comb begin
        req_any_s  = d_req | if_req;
        req_we_s   = 1'b0;
        req_addr_s = 32'd0;
        if (d_req) begin
            req_we_s   = d_we;
            req_addr_s = word_addr(d_addr);
        end else begin
            req_we_s   = 1'b0;
            req_addr_s = word_addr(if_addr);
        end
    end

    // Byte-offset bits are dropped in byte-address mode; MEM_DEPTH only matters to the range check.
    assign unused_bits_s = ^{if_addr[1:0], d_addr[1:0], 32'(MEM_DEPTH)};

    // Access sequencer: IDLE grants, ACCESS spans one memory falling edge, DONE holds the ack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            grant_d_r  <= 1'b0;
            cs_r       <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            if_rdata_r <= 32'd0;
            d_rdata_r  <= 32'd0;
            if_ack_r   <= 1'b0;
            d_ack_r    <= 1'b0;
`ifdef MEMCTL_ADDR_CHECK_EN
            err_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
`ifdef MEMCTL_ADDR_CHECK_EN
                    err_r    <= 1'b0;
                    if (req_any_s && addr_bad_s) begin
                        // Out-of-range: never touch the memory, finish immediately with err.
                        grant_d_r <= d_req;
                        d_ack_r   <= d_req;
                        if_ack_r  <= ~d_req;
                        err_r     <= 1'b1;
                        if (d_req) begin
                            if (!d_we) begin
                                d_rdata_r <= 32'd0;
                            end else begin
                                d_rdata_r <= d_rdata_r;
                            end
                        end else begin
                            if_rdata_r <= 32'd0;
                        end
                        state_r <= ST_DONE;
                    end else
`endif
                    if (req_any_s) begin
                        grant_d_r <= d_req;
                        addr_r    <= req_addr_s;
                        we_r      <= req_we_s;
                        wdata_r   <= d_wdata;
                        cs_r      <= 1'b1;
                        state_r   <= ST_ACCESS;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    cs_r <= 1'b0;
                    we_r <= 1'b0;
                    if (grant_d_r) begin
                        d_ack_r <= 1'b1;
                        if (!we_r) begin
                            d_rdata_r <= Mem_Bus;
                        end else begin
                            d_rdata_r <= d_rdata_r;
                        end
                    end else begin
                        if_ack_r   <= 1'b1;
                        if_rdata_r <= Mem_Bus;
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
`ifdef MEMCTL_ADDR_CHECK_EN
                    err_r    <= 1'b0;
`endif
                    state_r  <= ST_IDLE;
                end
                default: begin
                    cs_r     <= 1'b0;
                    we_r     <= 1'b0;
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
`ifdef MEMCTL_ADDR_CHECK_EN
                    err_r    <= 1'b0;
`endif
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign CS       = cs_r;
    assign WE       = we_r;
    assign ADDR     = addr_r;
    assign if_ack   = if_ack_r;
    assign d_ack    = d_ack_r;
    assign if_rdata = if_rdata_r;
    assign d_rdata  = d_rdata_r;
`ifdef MEMCTL_ADDR_CHECK_EN
    assign err      = err_r;
`endif

    // WE is only high during a write ACCESS, so the bus is released at all other times.
    assign Mem_Bus = we_r ? wdata_r : {32{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: word memory model on the shared bus plus a shadow-array reference.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_mem_bus_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
`ifdef MEMCTL_ADDR_CHECK_EN
    logic        err;
`endif
    logic        CS;
    logic        WE;
    logic [31:0] ADDR;
    wire  [31:0] Mem_Bus;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_bus_ctrl #(.MEM_DEPTH(128), .BYTE_ADDR(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
`ifdef MEMCTL_ADDR_CHECK_EN
        .err(err),
`endif
        .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(Mem_Bus)
    );

    // Memory model: drives read data while selected for read, writes on the falling edge.
    assign Mem_Bus = (CS && !WE) ? mem[ADDR[6:0]] : {32{1'bz}};
    always @(negedge CLK) begin
        if (CS && WE) mem[ADDR[6:0]] <= Mem_Bus;
    end

    task automatic test_reset();
        RST = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678;
        if_req = 1'b1; if_addr = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if ({CS, WE, if_ack, d_ack} !== 4'b0000) begin
                errors++; $display("FAIL reset_ctl: got %b expected 0000", {CS, WE, if_ack, d_ack});
            end
            checks++;
            if ({ADDR, if_rdata, d_rdata} !== 96'd0) begin
                errors++; $display("FAIL reset_data: got %h %h %h expected zeros", ADDR, if_rdata, d_rdata);
            end
        end
        RST = 1'b0; d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_store_load();
        repeat (2) @(negedge CLK);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        @(negedge CLK);
        checks++;
        if ({CS, WE, ADDR, Mem_Bus, d_ack} !== {1'b1, 1'b1, 32'd4, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL store_access: got CS=%b WE=%b ADDR=%h bus=%h ack=%b expected 1 1 4 deadbeef 0",
                               CS, WE, ADDR, Mem_Bus, d_ack);
        end
        @(negedge CLK);
        checks++;
        if ({d_ack, CS, WE} !== 3'b100) begin
            errors++; $display("FAIL store_ack: got ack/CS/WE %b expected 100", {d_ack, CS, WE});
        end
        ref_mem[4] = 32'hDEADBEEF;
        d_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (d_ack !== 1'b0) begin
            errors++; $display("FAIL ack_pulse: got %b expected 0", d_ack);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        @(negedge CLK);
        checks++;
        if ({CS, WE, ADDR, Mem_Bus} !== {1'b1, 1'b0, 32'd4, ref_mem[4]}) begin
            errors++; $display("FAIL load_access: got CS=%b WE=%b ADDR=%h bus=%h expected 1 0 4 %h",
                               CS, WE, ADDR, Mem_Bus, ref_mem[4]);
        end
        @(negedge CLK);
        checks++;
        if ({d_ack, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL load_data: got ack=%b data=%h expected 1 deadbeef", d_ack, d_rdata);
        end
        d_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        int d_cyc;
        int i_cyc;
        d_cyc = 0; i_cyc = 0;
        repeat (2) @(negedge CLK);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; if_req = 1'b1; if_addr = 32'h34;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            checks++;
            if (d_ack && if_ack) begin
                errors++; $display("FAIL sim_both_acks: cycle %0d both acks high, required at most one", c);
            end
            if (d_ack) begin d_cyc = c; d_req = 1'b0; end
            if (if_ack) begin i_cyc = c; if_req = 1'b0; end
        end
        checks++;
        if (d_cyc != 2 || i_cyc != 5) begin
            errors++; $display("FAIL sim_latency: got d_ack@%0d if_ack@%0d expected 2 and 5", d_cyc, i_cyc);
        end
        checks++;
        if ({d_rdata, if_rdata} !== {ref_mem[8], ref_mem[13]}) begin
            errors++; $display("FAIL sim_data: got %h %h expected %h %h", d_rdata, if_rdata, ref_mem[8], ref_mem[13]);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int last;
        int cs_cycles;
        k = 0; last = 0; cs_cycles = 0;
        repeat (2) @(negedge CLK);
        if_req = 1'b1; if_addr = 32'h0;
        for (int c = 1; c <= 20 && k < 3; c++) begin
            @(negedge CLK);
            if (CS) cs_cycles++;
            if (if_ack) begin
                checks++;
                if ((c - last) != ((k == 0) ? 2 : 3) || if_rdata !== ref_mem[k]) begin
                    errors++; $display("FAIL b2b_fetch%0d: got gap %0d data %h expected gap %0d data %h",
                                       k, c - last, if_rdata, (k == 0) ? 2 : 3, ref_mem[k]);
                end
                last = c; k++;
                if_addr = 32'(k * 4);
                if (k == 3) if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        @(negedge CLK);
        if (CS) cs_cycles++;
        checks++;
        if (k != 3 || cs_cycles != 3) begin
            errors++; $display("FAIL b2b_count: got %0d acks %0d CS cycles expected 3 and 3", k, cs_cycles);
        end
    endtask

    task automatic test_reset_access();
        logic [31:0] nd;
        int seen;
        nd = $urandom;
        seen = 0;
        repeat (2) @(negedge CLK);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1C; d_wdata = nd;
        @(negedge CLK);
        checks++;
        if ({CS, WE, ADDR} !== {1'b1, 1'b1, 32'd7}) begin
            errors++; $display("FAIL rst_acc_issue: got CS=%b WE=%b ADDR=%h expected 1 1 7", CS, WE, ADDR);
        end
        RST = 1'b1; d_req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({CS, WE, d_ack, d_rdata} !== 35'd0) begin
            errors++; $display("FAIL rst_acc_abort: got CS=%b WE=%b ack=%b rdata=%h expected all 0", CS, WE, d_ack, d_rdata);
        end
        ref_mem[7] = nd;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (d_ack) seen++;
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1C;
        for (int c = 0; c < 6 && seen < 10; c++) begin
            @(negedge CLK);
            if (d_ack) begin seen = 10 + seen; d_req = 1'b0; end
        end
        d_req = 1'b0;
        checks++;
        if (seen != 10 || d_rdata !== ref_mem[7]) begin
            errors++; $display("FAIL rst_acc_commit: got ack-code %0d data %h expected 10 %h", seen, d_rdata, ref_mem[7]);
        end
    endtask

`ifdef MEMCTL_ADDR_CHECK_EN
    task automatic test_addr_check();
        int cs_seen;
        cs_seen = 0;
        repeat (2) @(negedge CLK);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = ~ref_mem[0];
        @(negedge CLK);
        checks++;
        if ({d_ack, err, CS} !== 3'b110) begin
            errors++; $display("FAIL addr_chk_reject: got ack/err/CS %b expected 110", {d_ack, err, CS});
        end
        d_req = 1'b0;
        repeat (3) begin @(negedge CLK); if (CS) cs_seen++; end
        checks++;
        if (cs_seen != 0 || mem[0] !== ref_mem[0]) begin
            errors++; $display("FAIL addr_chk_mem: got CS cycles %0d word0 %h expected 0 %h", cs_seen, mem[0], ref_mem[0]);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
        @(negedge CLK);
        checks++;
        if ({d_ack, err, d_rdata} !== {1'b1, 1'b1, 32'd0}) begin
            errors++; $display("FAIL addr_chk_read: got ack=%b err=%b data=%h expected 1 1 0", d_ack, err, d_rdata);
        end
        d_req = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int mode;
            int d_cyc;
            int i_cyc;
            logic [6:0] dw;
            logic [6:0] iw;
            logic we;
            logic [31:0] wd;
            mode = int'($urandom_range(0, 2));
            dw = 7'($urandom); iw = 7'($urandom); we = 1'($urandom); wd = $urandom;
            d_cyc = 0; i_cyc = 0;
            repeat (2) @(negedge CLK);
            if (mode != 1) begin
                d_req = 1'b1; d_we = we; d_addr = {23'd0, dw, 2'($urandom)}; d_wdata = wd;
            end
            if (mode != 0) begin
                if_req = 1'b1; if_addr = {23'd0, iw, 2'($urandom)};
            end
            for (int c = 1; c <= 8; c++) begin
                @(negedge CLK);
                if (c == 1) begin
                    checks++;
                    if ({CS, WE, ADDR} !== {1'b1, (mode != 1) && we, 32'((mode != 1) ? dw : iw)}) begin
                        errors++; $display("FAIL rnd_issue%0d: got CS=%b WE=%b ADDR=%h expected 1 %b %h", t, CS, WE, ADDR,
                                           (mode != 1) && we, (mode != 1) ? dw : iw);
                    end
                end
                checks++;
                if (d_ack && if_ack) begin
                    errors++; $display("FAIL rnd_both%0d: both acks high at cycle %0d, required at most one", t, c);
                end
                if (d_ack) begin
                    d_cyc = c; d_req = 1'b0;
                    if (we) begin
                        ref_mem[dw] = wd;
                    end else begin
                        checks++;
                        if (d_rdata !== ref_mem[dw]) begin
                            errors++; $display("FAIL rnd_load%0d: got %h expected %h", t, d_rdata, ref_mem[dw]);
                        end
                    end
                end
                if (if_ack) begin
                    i_cyc = c; if_req = 1'b0;
                    checks++;
                    if (if_rdata !== ref_mem[iw]) begin
                        errors++; $display("FAIL rnd_fetch%0d: got %h expected %h", t, if_rdata, ref_mem[iw]);
                    end
                end
            end
            checks++;
            if (d_cyc != ((mode != 1) ? 2 : 0) || i_cyc != ((mode == 0) ? 0 : ((mode == 1) ? 2 : 5))) begin
                errors++; $display("FAIL rnd_latency%0d: got d@%0d i@%0d for mode %0d", t, d_cyc, i_cyc, mode);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_store_load();
        test_simultaneous();
        test_back_to_back();
        test_reset_access();
`ifdef MEMCTL_ADDR_CHECK_EN
        test_addr_check();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
